// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: state codes, opcodes
// and the datapath mux/ALU select codes driven by the controller.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_RWB      = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_IWB      = 4'd9,
    ST_JR       = 4'd10
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_RTYPE = 6'b011010;
  localparam logic [5:0] OP_JR    = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSA = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] ASRCB_REGB = 2'b00;
  localparam logic [1:0] ASRCB_FOUR = 2'b01;
  localparam logic [1:0] ASRCB_SEXT = 2'b10;
  localparam logic [1:0] ASRCB_ZEXT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_REGA   = 2'b10;

  // One-hot instruction class produced by mc_opclass_decode.
  typedef struct packed {
    logic mem;
    logic rtype;
    logic imm;
    logic jr;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/mc_opclass_decode.sv
// Combinational opcode classifier: one-hot class plus a store flag that
// splits the memory class into lw/sw.
module mc_opclass_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  output opclass_t   o_class,
  output logic       o_store
);

  always_comb begin
    o_class = '0;
    o_store = 1'b0;
    case (i_opcode)
      OP_LW:          o_class.mem   = 1'b1;
      OP_SW: begin
        o_class.mem = 1'b1;
        o_store     = 1'b1;
      end
      OP_RTYPE:       o_class.rtype = 1'b1;
      OP_ORI, OP_LUI: o_class.imm   = 1'b1;
      OP_JR:          o_class.jr    = 1'b1;
      default:        o_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle sequencing controller: registered state plus one combinational
// block producing next state and the per-cycle datapath enables.
module mc_controller
  import mips_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       memtoreg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t   r_state;
  state_t   w_next;
  opclass_t w_class;
  logic     w_store;

  mc_opclass_decode u_dec (
    .i_opcode (opcode),
    .o_class  (w_class),
    .o_store  (w_store)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= state_t'(RESET_STATE);
    else     r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    alusrc_a      = 1'b0;
    alusrc_b      = ASRCB_REGB;
    aluop         = ALUOP_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    memtoreg      = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = ASRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alusrc_b = ASRCB_SEXT;
        if (w_class.mem)        w_next = ST_MEMADDR;
        else if (w_class.rtype) w_next = ST_EXEC_R;
        else if (w_class.imm)   w_next = ST_EXEC_I;
        else if (w_class.jr)    w_next = ST_JR;
        else begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          w_next     = ST_FETCH;
        end
      end
      ST_MEMADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = ASRCB_SEXT;
        w_next   = w_store ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        alusrc_a = 1'b1;
        alusrc_b = ASRCB_REGB;
        aluop    = ALUOP_FUNCT;
        w_next   = ST_RWB;
      end
      ST_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_EXEC_I: begin
        alusrc_a = 1'b1;
        alusrc_b = ASRCB_ZEXT;
        aluop    = ALUOP_IMM;
        w_next   = ST_IWB;
      end
      ST_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_JR: begin
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_REGA;
        instr_done    = 1'b1;
        w_next        = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase

    // While reset is held the instruction in flight is abandoned: present the
    // FETCH request but never commit a write or signal completion.
    if (rst) begin
      mem_req       = 1'b1;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = PCSRC_ALU;
      alusrc_a      = 1'b0;
      alusrc_b      = ASRCB_FOUR;
      aluop         = ALUOP_ADD;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      memtoreg      = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle sequencing controller for the MIPS core. It replaces single-cycle opcode decoding with a state machine that steps one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and write-back. It handles the memory wait-state handshake and emits per-cycle datapath enables. It sits between the instruction register's opcode field and the datapath muxes and enables.

## Interface
Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); kept as a parameter only for bench overrides.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instruction[31:26] from the IR; valid from DECODE onward
- mem_ready  input  1  memory completes the current access in this cycle
- mem_req  output  1  memory access request; held until mem_ready
- mem_we  output  1  write qualifier for mem_req
- iord  output  1  0 = address from PC, 1 = address from ALUOut
- ir_write  output  1  load the IR from memory read data
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  conditional PC load (jr path)
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = register A (jr)
- alusrc_a  output  1  0 = PC, 1 = register A
- alusrc_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = zero-extended or upper immediate
- aluop  output  2  00 = add, 01 = pass A, 10 = funct-driven, 11 = immediate class (ALU control uses {opcode[2],opcode[0]})
- reg_write, reg_dst, memtoreg  output  1 each  register-file write enable, rd/rt select, and MDR/ALUOut select
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  output  4  current state, for debug and the bench

## Operation
- Supported opcodes: lw 100011, sw 101011, ori 001110, lui 001111, R-type/mul 011010, jr 001000. All other opcodes are illegal.
- States: FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, RWB, EXEC_I, IWB, JR.
- FETCH:
  - Asserts mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluop=00.
  - While mem_ready=0, it stays in FETCH with ir_write and pc_write held at 0.
  - In the cycle mem_ready=1, it asserts ir_write=1 and pc_write=1 (pc_src=00), then moves to DECODE.
- DECODE: computes the branch target only (alusrc_a=0, alusrc_b=10, aluop=00). Next state by opcode:
  - lw/sw → MEMADDR
  - 011010 → EXEC_R
  - ori/lui → EXEC_I
  - jr → JR
  - anything else → FETCH, with illegal_op=1 and instr_done=1
- MEMADDR: alusrc_a=1, alusrc_b=10, aluop=00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, iord=1. Waits on mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, memtoreg=1, instr_done=1, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, iord=1. Waits on mem_ready; in the mem_ready cycle it pulses instr_done, then goes to FETCH.
- EXEC_R: alusrc_a=1, alusrc_b=00, aluop=10, then RWB.
- RWB: reg_write=1, reg_dst=1, memtoreg=0, instr_done=1, then FETCH.
- EXEC_I: alusrc_a=1, alusrc_b=11, aluop=11, then IWB.
- IWB: reg_write=1, reg_dst=0, memtoreg=0, instr_done=1, then FETCH.
- JR: pc_write_cond=1, pc_src=10, instr_done=1, then FETCH.
- Output rules:
  - All outputs are Moore decodes of state, except ir_write, pc_write and instr_done, which in memory states are additionally qualified by mem_ready.
  - Any output not listed for a state is 0.
  - mem_we is never 1 without mem_req.

## Timing
- Reset: rst=1 at a rising edge forces state=FETCH. All outputs then take FETCH values: mem_req=1, alusrc_b=01, everything else 0.
- Reset applied mid-instruction (including during a MEMWRITE wait) abandons the instruction. No instr_done pulse is issued and no write-enable is asserted in the cycle after the reset edge.
- Latency with zero wait states (mem_ready=1 on first request):
  - jr: 3 cycles
  - R-type, ori, lui, sw: 4 cycles
  - lw: 5 cycles
  - illegal opcode: 2 cycles
- Each memory wait cycle adds exactly one cycle.
- Handshake:
  - mem_req stays asserted continuously from state entry until the mem_ready cycle.
  - A mem_ready=1 seen outside a memory state is ignored.
- opcode is sampled only in DECODE and MEMADDR. Changes to opcode in other states have no effect.

## Structure
- Shared package mips_pkg holds:
  - the 4-bit state encoding typedef
  - opcode localparams (OP_LW, OP_SW, OP_ORI, OP_LUI, OP_RTYPE, OP_JR)
  - aluop, alusrc_b and pc_src code constants
- Sub-module mc_opclass_decode: combinational map from opcode to a one-hot class {mem, rtype, imm, jr, illegal}. DECODE and MEMADDR both use it.
- Top-level structure: a registered state plus one combinational next-state/output block.

## Test plan
- Reset: hold rst=1 for 2 cycles with mem_ready=1 → state=FETCH, mem_req=1, alusrc_b=01, every write-enable 0.
- lw: opcode=100011 with zero wait states → state sequence FETCH, DECODE, MEMADDR, MEMREAD, MEMWB; reg_write=1 and memtoreg=1 only in cycle 5; instr_done pulses once.
- sw with wait states: opcode=101011, mem_ready low for 3 cycles in MEMWRITE → mem_we=1 for 4 cycles, instr_done pulses in the 4th cycle, reg_write never 1.
- R-type then ori back-to-back: opcodes 011010 then 001110 → reg_dst=1 in RWB and 0 in IWB; aluop=10 in EXEC_R and 11 in EXEC_I; 8 cycles total.
- jr and illegal: opcode 001000 → pc_write_cond=1 with pc_src=10 on cycle 3. Opcode 000100 → illegal_op=1 in DECODE, then FETCH.
- Reset in MEMREAD: assert rst while mem_ready=0 → next cycle is FETCH, with no reg_write and no instr_done.
